mem_access_unit: RTL

//  MEM-stage load/store engine; sits between the EX/MEM register and the MEM/WB register.

---
 rtl/mem_access_unit_pkg.sv | 23 ++
 rtl/mem_access_unit_if.sv | 24 ++
 rtl/mem_access_unit_lsu_align.sv | 56 +++++
 rtl/mem_access_unit.sv | 133 +++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared constants and types for the MEM-stage load/store unit.
package mem_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB = F3_LB;
  localparam logic [2:0] F3_SH = F3_LH;
  localparam logic [2:0] F3_SW = F3_LW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mau_state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// Wishbone B4 classic bundle between the MEM-stage access unit (master) and memory (slave).
interface mem_access_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    wb_cyc_o;
  logic                    wb_stb_o;
  logic                    wb_we_o;
  logic [ADDR_WIDTH-1:0]   wb_adr_o;
  logic [DATA_WIDTH-1:0]   wb_dat_o;
  logic [DATA_WIDTH/8-1:0] wb_sel_o;
  logic [DATA_WIDTH-1:0]   wb_dat_i;
  logic                    wb_ack_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/mem_access_unit_lsu_align.sv
// Byte-lane steering: store packing, load extraction/extension and alignment check.
module lsu_align
  import mem_pkg::*;
(
  input  logic [2:0]  req_funct3_i,
  input  logic [1:0]  req_off_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  sel_o,
  output logic [31:0] dat_o,
  output logic        misaligned_o,
  input  logic [2:0]  rsp_funct3_i,
  input  logic [1:0]  rsp_off_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] load_data_o
);

  logic [7:0]  loadByte;
  logic [15:0] loadHalf;

  // Unlisted funct3 encodings fall into the word case on both paths.
  always_comb begin
    sel_o        = 4'b1111;
    dat_o        = wdata_i;
    misaligned_o = 1'b0;
    case (req_funct3_i)
      F3_LB, F3_LBU: begin
        sel_o = 4'b0001 << req_off_i;
        dat_o = {4{wdata_i[7:0]}};
      end
      F3_LH, F3_LHU: begin
        sel_o        = 4'b0011 << req_off_i;
        dat_o        = {2{wdata_i[15:0]}};
        misaligned_o = req_off_i[0];
      end
      default: begin
        sel_o        = 4'b1111;
        dat_o        = wdata_i;
        misaligned_o = |req_off_i;
      end
    endcase
  end

  always_comb begin
    loadByte    = rdata_i[{rsp_off_i, 3'b000} +: 8];
    loadHalf    = rdata_i[{rsp_off_i[1], 4'b0000} +: 16];
    load_data_o = rdata_i;
    case (rsp_funct3_i)
      F3_LB:   load_data_o = {{24{loadByte[7]}}, loadByte};
      F3_LBU:  load_data_o = {24'h000000, loadByte};
      F3_LH:   load_data_o = {{16{loadHalf[15]}}, loadHalf};
      F3_LHU:  load_data_o = {16'h0000, loadHalf};
      default: load_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: one outstanding Wishbone classic access, stalls the pipe until done.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] wdata_in,
  output logic [DATA_WIDTH-1:0] memory_data_out,
  output logic                  mem_stall,
  output logic                  misaligned,
  mem_access_unit_if.master     wb
);

  mau_state_t state_q, state_d;

  logic [ADDR_WIDTH-3:0]   wordAddr_q;
  logic [1:0]              off_q;
  logic [DATA_WIDTH-1:0]   wdat_q;
  logic [DATA_WIDTH/8-1:0] sel_q;
  logic                    we_q;
  logic [2:0]              f3_q;
  logic                    flushed_q, flushed_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic                    accept;
  logic                    busy;
  logic                    reqMisaligned;
  logic [DATA_WIDTH/8-1:0] packSel;
  logic [DATA_WIDTH-1:0]   packDat;
  logic [DATA_WIDTH-1:0]   loadData;

  lsu_align u_align (
    .req_funct3_i (funct3),
    .req_off_i    (addr_in[1:0]),
    .wdata_i      (wdata_in),
    .sel_o        (packSel),
    .dat_o        (packDat),
    .misaligned_o (reqMisaligned),
    .rsp_funct3_i (f3_q),
    .rsp_off_i    (off_q),
    .rdata_i      (wb.wb_dat_i),
    .load_data_o  (loadData)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wordAddr_q <= '0;
      off_q      <= '0;
      wdat_q     <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      f3_q       <= '0;
      flushed_q  <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q   <= state_d;
      flushed_q <= flushed_d;
      rdata_q   <= rdata_d;
      if (accept) begin
        wordAddr_q <= addr_in[ADDR_WIDTH-1:2];
        off_q      <= addr_in[1:0];
        wdat_q     <= packDat;
        sel_q      <= packSel;
        we_q       <= MemWrite;
        f3_q       <= funct3;
      end
    end
  end

  // reset gates the IDLE request decode so every output reads 0 while reset is held.
  always_comb begin
    state_d    = state_q;
    flushed_d  = flushed_q;
    rdata_d    = rdata_q;
    accept     = 1'b0;
    mem_stall  = 1'b0;
    misaligned = 1'b0;
    case (state_q)
      IDLE: begin
        if (reset && (MemRead || MemWrite) && !flush) begin
          if (reqMisaligned) begin
            misaligned = 1'b1;
          end else begin
            accept    = 1'b1;
            mem_stall = 1'b1;
            flushed_d = 1'b0;
            state_d   = BUSY;
          end
        end
      end
      BUSY: begin
        mem_stall = 1'b1;
        if (flush) begin
          flushed_d = 1'b1;
        end
        if (wb.wb_ack_i) begin
          flushed_d = 1'b0;
          if (flush || flushed_q) begin
            state_d = IDLE;
          end else begin
            state_d = DONE;
            rdata_d = we_q ? '0 : loadData;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy            = (state_q == BUSY);
  assign wb.wb_cyc_o     = busy;
  assign wb.wb_stb_o     = busy;
  assign wb.wb_we_o      = busy & we_q;
  assign wb.wb_adr_o     = busy ? {wordAddr_q, 2'b00} : '0;
  assign wb.wb_dat_o     = busy ? wdat_q : '0;
  assign wb.wb_sel_o     = busy ? sel_q : '0;
  assign memory_data_out = rdata_q;

endmodule
